// File: rtl/simon_pkg.sv
// Shared constants and state type for the SIMON byte loader.
// Command bytes select the frame type; widths match the cipher core.
package simon_pkg;

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_PT  = 8'h50;

  localparam int KEY_W = 64;
  localparam int BLK_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    PT,
    ISSUE,
    GAP
  } loader_state_t;

endpackage

// File: rtl/simon_byte_loader.sv
// Byte-serial loader that assembles the key and plaintext for simon_pipeline
// and issues one start pulse per plaintext block.
//
// state | meaning
// IDLE  | waiting for a command byte (din_ready=1)
// KEY   | collecting KEY_BYTES key payload bytes
// PT    | collecting PT_BYTES plaintext payload bytes
// ISSUE | start pulse, plaintext valid, din_ready=0
// GAP   | START_GAP idle cycles with din_ready=0
module simon_byte_loader
  import simon_pkg::*;
#(
  parameter int KEY_BYTES = 8,
  parameter int PT_BYTES  = 4,
  parameter int START_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [KEY_W-1:0] keytext,
  output logic [BLK_W-1:0] plaintext,
  output logic             start,
  output logic             key_loaded,
  output logic             err
);

  localparam logic [3:0] KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0] PT_LAST  = 4'(PT_BYTES - 1);
  localparam int         GAP_INIT = (START_GAP > 0) ? START_GAP - 1 : 0;

  loader_state_t    state, state_n;
  logic [3:0]       cnt;
  logic [3:0]       gap_cnt;
  logic [KEY_W-1:0] key_sh;
  logic [BLK_W-1:0] pt_sh;
  logic             accept;
  logic             xfer;
  logic             bad_cmd;

  // Ready is decoded from state only, and forced low while reset is held.
  assign accept    = (state == IDLE) || (state == KEY) || (state == PT);
  assign din_ready = accept & rst;
  assign xfer      = din_valid & din_ready;
  assign start     = (state == ISSUE);
  assign bad_cmd   = !((din == CMD_KEY) || (din == CMD_PT && key_loaded));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (xfer && din == CMD_KEY)                 state_n = KEY;
        else if (xfer && din == CMD_PT && key_loaded) state_n = PT;
      end
      KEY:   if (xfer && cnt == KEY_LAST) state_n = IDLE;
      PT:    if (xfer && cnt == PT_LAST)  state_n = ISSUE;
      ISSUE: state_n = (START_GAP > 0) ? GAP : IDLE;
      GAP:   if (gap_cnt == 4'd0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      gap_cnt    <= 4'd0;
      key_sh     <= '0;
      pt_sh      <= '0;
      keytext    <= '0;
      plaintext  <= '0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            cnt <= 4'd0;
            err <= bad_cmd;
          end
        end
        KEY: begin
          if (xfer) begin
            key_sh <= {key_sh[KEY_W-9:0], din};
            if (cnt == KEY_LAST) begin
              keytext    <= {key_sh[KEY_W-9:0], din};
              key_loaded <= 1'b1;
              cnt        <= 4'd0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        PT: begin
          if (xfer) begin
            pt_sh <= {pt_sh[BLK_W-9:0], din};
            if (cnt == PT_LAST) begin
              plaintext <= {pt_sh[BLK_W-9:0], din};
              cnt       <= 4'd0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ISSUE: gap_cnt <= 4'(GAP_INIT);
        GAP:   if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_byte_loader.sv
// Self-checking bench for simon_byte_loader: directed frames plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_simon_byte_loader;

  localparam int GAP_P = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [63:0] keytext;
  logic [31:0] plaintext;
  logic        start;
  logic        key_loaded;
  logic        err;

  int tests = 0;
  int fails = 0;

  simon_byte_loader #(.KEY_BYTES(8), .PT_BYTES(4), .START_GAP(GAP_P)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .keytext    (keytext),
    .plaintext  (plaintext),
    .start      (start),
    .key_loaded (key_loaded),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: parses the accepted byte stream frame by frame and
  // derives start/err/ready timing from the latency rules.
  longint      cyc = 0;
  longint      ready_from = 0;
  longint      start_at = -1;
  longint      err_at = -1;
  logic [63:0] m_key = '0;
  logic [31:0] m_pt = '0;
  bit          m_kl = 1'b0;
  int          need = 0;
  bit          is_key = 1'b0;
  logic [7:0]  q[$];

  always @(posedge clk) begin : model
    bit          rdy;
    logic [63:0] v;
    rdy = rst && (cyc >= ready_from);
    cyc++;
    if (!rst) begin
      ready_from = cyc;
      start_at   = -1;
      err_at     = -1;
      m_key      = '0;
      m_pt       = '0;
      m_kl       = 1'b0;
      need       = 0;
      q.delete();
    end else if (rdy && din_valid) begin
      if (need == 0) begin
        if (din == 8'h4B) begin
          need = 8; is_key = 1'b1; q.delete();
        end else if (din == 8'h50 && m_kl) begin
          need = 4; is_key = 1'b0; q.delete();
        end else begin
          err_at = cyc;
        end
      end else begin
        q.push_back(din);
        if (q.size() == need) begin
          v = '0;
          foreach (q[i]) v = (v << 8) | 64'(q[i]);
          if (is_key) begin
            m_key = v;
            m_kl  = 1'b1;
          end else begin
            m_pt       = v[31:0];
            start_at   = cyc;
            ready_from = cyc + GAP_P + 1;
          end
          need = 0;
        end
      end
    end
  end

  int     start_seen = 0;
  int     err_seen = 0;
  longint last_start = 0;
  longint prev_start = 0;

  always @(negedge clk) begin : compare
    if (!rst) begin
      chk("rst_din_ready", din_ready, 0);
      chk("rst_start", start, 0);
      chk("rst_err", err, 0);
      chk("rst_keytext", keytext, 0);
      chk("rst_plaintext", plaintext, 0);
      chk("rst_key_loaded", key_loaded, 0);
    end else begin
      chk("din_ready", din_ready, (cyc >= ready_from) ? 1 : 0);
      chk("start", start, (cyc == start_at) ? 1 : 0);
      chk("err", err, (cyc == err_at) ? 1 : 0);
      chk("keytext", keytext, m_key);
      chk("plaintext", plaintext, 64'(m_pt));
      chk("key_loaded", key_loaded, 64'(m_kl));
    end
    if (start === 1'b1) begin
      start_seen++;
      prev_start = last_start;
      last_start = cyc;
    end
    if (err === 1'b1) err_seen++;
  end

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int   guard;
    logic r;
    din       = b;
    din_valid = 1'b1;
    guard     = 0;
    do begin
      r = din_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!r && guard < 50);
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, guard);
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic send_key(input logic [63:0] k);
    send(8'h4B);
    for (int i = 7; i >= 0; i--) send(k[i*8 +: 8]);
  endtask

  task automatic send_pt(input logic [31:0] p);
    send(8'h50);
    for (int i = 3; i >= 0; i--) send(p[i*8 +: 8]);
  endtask

  int base;

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    base = start_seen;
    send_key(64'h1918111009080100);
    idle(2);
    chk("key_literal", keytext, 64'h1918111009080100);
    chk("key_loaded_literal", key_loaded, 1);
    chk("no_start_on_key", start_seen - base, 0);

    send_pt(32'h65656877);
    idle(6);
    chk("pt_literal", plaintext, 64'h65656877);
    chk("one_start_per_block", start_seen - base, 1);

    do_reset();
    base = err_seen;
    send(8'h50);
    idle(2);
    chk("err_pt_without_key", err_seen - base, 1);
    chk("no_key_after_err", key_loaded, 0);
    send(8'hFF);
    idle(2);
    chk("err_bad_cmd", err_seen - base, 2);
    send_key(64'hA1B2C3D4E5F60718);
    send_pt(32'hDEADBEEF);
    idle(6);
    chk("pt_after_errors", plaintext, 64'hDEADBEEF);

    // Back-to-back blocks with din_valid held high: 5-byte frame plus 4 stall cycles.
    send_pt(32'h01020304);
    send_pt(32'h05060708);
    idle(6);
    chk("start_spacing", last_start - prev_start, 9);
    chk("pt_second_block", plaintext, 64'h05060708);

    do_reset();
    send(8'h4B);
    send(8'h01);
    send(8'h02);
    idle(10);
    for (int i = 3; i <= 8; i++) send(8'(i));
    idle(2);
    chk("key_after_stall", keytext, 64'h0102030405060708);

    send(8'h4B);
    for (int i = 0; i < 5; i++) send(8'hEE);
    do_reset();
    chk("key_cleared_by_reset", keytext, 0);
    chk("key_loaded_cleared", key_loaded, 0);
    send_key(64'h0F0E0D0C0B0A0908);
    send_pt(32'h11223344);
    idle(6);
    chk("key_after_reset", keytext, 64'h0F0E0D0C0B0A0908);
    chk("pt_after_reset", plaintext, 64'h11223344);

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        send(8'h4B);
        for (int i = 0; i < 8; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(8'($urandom));
        end
      end else if (kind <= 7) begin
        send(8'h50);
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(8'($urandom));
        end
      end else if (kind == 8) begin
        send(8'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        idle($urandom_range(1, 4));
      end
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
